branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/rv32i_pkg.sv | 39 +++
 rtl/br_perf_ctr.sv | 33 +++
 rtl/branch_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: conditional-branch funct3 encodings and the
// branch-condition evaluation used by the branch controller.
package rv32i_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_f3_e;

    typedef struct packed {
        logic taken;
        logic illegal;
    } branch_eval_t;

    // Signed/unsigned variants share Lt; the comparator mode is chosen via BrUn.
    function automatic branch_eval_t evalBranch(
        input logic [2:0] f3,
        input logic       eq,
        input logic       lt
    );
        branch_eval_t result;
        result = '0;
        case (f3)
            BEQ:     result.taken = eq;
            BNE:     result.taken = !eq;
            BLT:     result.taken = lt;
            BGE:     result.taken = !lt;
            BLTU:    result.taken = lt;
            BGEU:    result.taken = !lt;
            default: result.illegal = 1'b1;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/br_perf_ctr.sv
// Branch performance counters: accepted branches and taken, aligned redirects.
// Both wrap at 32 bits and clear synchronously.
module br_perf_ctr (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branchInc_i,
    input  logic        takenInc_i,
    output logic [31:0] branchCnt_o,
    output logic [31:0] takenCnt_o
);

    logic [31:0] branchCnt_q;
    logic [31:0] branchCnt_d;
    logic [31:0] takenCnt_q;
    logic [31:0] takenCnt_d;

    assign branchCnt_d = branchCnt_q + {31'd0, branchInc_i};
    assign takenCnt_d  = takenCnt_q + {31'd0, takenInc_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branchCnt_q <= 32'd0;
            takenCnt_q  <= 32'd0;
        end else begin
            branchCnt_q <= branchCnt_d;
            takenCnt_q  <= takenCnt_d;
        end
    end

    assign branchCnt_o = branchCnt_q;
    assign takenCnt_o  = takenCnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// Conditional-branch controller: accepts one branch at a time, resolves it a
// cycle later into a redirect, a misalignment or an illegal-funct3 pulse.
module branch_ctrl
    import rv32i_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        BrUn,
    input  logic        Eq,
    input  logic        Lt,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        FLUSH
    } state_e;

    state_e       state_q;
    logic         taken_q;
    logic [2:0]   flushCnt_q;
    logic [31:0]  redirectPc_q;
    logic         redirectValid_q;
    logic         flush_q;
    logic         misalign_q;
    logic         illegal_q;

    logic         accept;
    logic [31:0]  target;
    logic         targetAligned;
    branch_eval_t evalNow;
    logic         takenInc;

    assign br_ready      = (state_q == IDLE);
    assign BrUn          = (state_q == IDLE) && !rst && funct3[1];
    assign accept        = br_valid && br_ready;
    assign target        = pc + imm;
    assign targetAligned = (target[1:0] == 2'b00);
    assign evalNow       = evalBranch(funct3, Eq, Lt);
    assign takenInc      = (state_q == RESOLVE) && taken_q && (redirectPc_q[1:0] == 2'b00);

    // Resolution outputs are decided at the accept edge so they appear
    // registered during RESOLVE, exactly one cycle after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            taken_q         <= 1'b0;
            flushCnt_q      <= 3'd0;
            redirectPc_q    <= 32'd0;
            redirectValid_q <= 1'b0;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            redirectValid_q <= 1'b0;
            misalign_q      <= 1'b0;
            illegal_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q         <= RESOLVE;
                        redirectPc_q    <= target;
                        taken_q         <= evalNow.taken;
                        redirectValid_q <= evalNow.taken && targetAligned;
                        flush_q         <= evalNow.taken && targetAligned;
                        misalign_q      <= evalNow.taken && !targetAligned;
                        illegal_q       <= evalNow.illegal;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                RESOLVE: begin
                    if (takenInc) begin
                        state_q    <= FLUSH;
                        flushCnt_q <= 3'(FLUSH_CYCLES);
                        flush_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flushCnt_q <= 3'd1) begin
                        state_q    <= IDLE;
                        flushCnt_q <= 3'd0;
                        flush_q    <= 1'b0;
                    end else begin
                        flushCnt_q <= flushCnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;
    assign flush          = flush_q;
    assign misalign       = misalign_q;
    assign illegal        = illegal_q;

    br_perf_ctr uPerf (
        .clk_i       (clk),
        .rst_i       (rst),
        .branchInc_i (accept),
        .takenInc_i  (takenInc),
        .branchCnt_o (branch_cnt),
        .takenCnt_o  (taken_cnt)
    );

endmodule
